// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the trap/interrupt sequencer: CSR addresses, cause codes,
// mstatus bit positions and FSM state encodings.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Exception code field only; the interrupt flag is carried separately as the cause MSB.
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_EXT_IRQ = 4'd11;
  localparam logic [3:0] CAUSE_TMR_IRQ = 4'd7;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_W_MEPC      = 3'd1;
  localparam logic [2:0] S_W_MSTATUS   = 3'd2;
  localparam logic [2:0] S_W_MCAUSE    = 3'd3;
  localparam logic [2:0] S_ASSERT      = 3'd4;
  localparam logic [2:0] S_MRET_W      = 3'd5;
  localparam logic [2:0] S_MRET_ASSERT = 3'd6;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// CSR register-file interrupt port: write strobe/address/data out of the sequencer,
// current mtvec/mepc/mstatus and global interrupt enable back in.
interface csr_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            csr_we;
  logic [XLEN-1:0] csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic [XLEN-1:0] csr_mstatus;
  logic            global_int_en;

  modport master (
    output csr_we, csr_waddr, csr_wdata,
    input  csr_mtvec, csr_mepc, csr_mstatus, global_int_en
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata,
    output csr_mtvec, csr_mepc, csr_mstatus, global_int_en
  );
endinterface

// File: rtl/csr_trap_ctrl_trap_cause_arb.sv
// Combinational priority encoder: ecall > ebreak > mret > external irq > timer irq.
module trap_cause_arb
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            global_int_en,
  output logic            evt_valid,
  output logic            is_mret,
  output logic            is_irq,
  output logic [XLEN-1:0] cause
);
  logic [3:0] code;

  always_comb begin
    evt_valid = 1'b1;
    is_mret   = 1'b0;
    is_irq    = 1'b0;
    code      = 4'd0;
    if (ecall) begin
      code = CAUSE_ECALL;
    end else if (ebreak) begin
      code = CAUSE_EBREAK;
    end else if (mret) begin
      is_mret = 1'b1;
    end else if (ext_irq && global_int_en) begin
      is_irq = 1'b1;
      code   = CAUSE_EXT_IRQ;
    end else if (tmr_irq && global_int_en) begin
      is_irq = 1'b1;
      code   = CAUSE_TMR_IRQ;
    end else begin
      evt_valid = 1'b0;
    end
  end

  assign cause = {is_irq, {(XLEN-5){1'b0}}, code};

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/interrupt sequencer: holds the pipeline, writes mepc/mstatus/mcause, then redirects fetch.
// Define INT_VECTORED_EN to honour vectored mtvec mode for interrupts.
//
// state         | meaning
// S_IDLE        | watch for events; hold asserted combinationally on detect
// S_W_MEPC      | write return address to mepc
// S_W_MSTATUS   | write mstatus with MPIE<=MIE, MIE<=0
// S_W_MCAUSE    | write captured cause to mcause
// S_ASSERT      | one-cycle redirect to trap vector
// S_MRET_W      | write mstatus with MIE<=MPIE, MPIE<=1
// S_MRET_ASSERT | one-cycle redirect to mepc
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            ext_irq_i,
  input  logic            tmr_irq_i,
  csr_trap_ctrl_if.master csr,
  output logic            hold_flag_o,
  output logic            int_assert_o,
  output logic [XLEN-1:0] int_addr_o
);
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] cause_q, ret_addr_q, ret_addr_d;
  logic            evt_valid, evt_mret, evt_irq;
  logic [XLEN-1:0] evt_cause;
  logic [XLEN-1:0] mst_trap, mst_mret, trap_target;

  trap_cause_arb #(.XLEN(XLEN)) u_arb (
    .ecall         (ecall_i),
    .ebreak        (ebreak_i),
    .mret          (mret_i),
    .ext_irq       (ext_irq_i),
    .tmr_irq       (tmr_irq_i),
    .global_int_en (csr.global_int_en),
    .evt_valid     (evt_valid),
    .is_mret       (evt_mret),
    .is_irq        (evt_irq),
    .cause         (evt_cause)
  );

  // Interrupts resume after the interrupted flow, honouring a redirect already in EX.
  assign ret_addr_d = evt_irq ? (jump_flag_i ? jump_addr_i : inst_addr_i + XLEN'(4))
                              : inst_addr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cause_q    <= '0;
      ret_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && evt_valid && !evt_mret) begin
        cause_q    <= evt_cause;
        ret_addr_q <= ret_addr_d;
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:        state_d = evt_valid ? (evt_mret ? S_MRET_W : S_W_MEPC) : S_IDLE;
      S_W_MEPC:      state_d = S_W_MSTATUS;
      S_W_MSTATUS:   state_d = S_W_MCAUSE;
      S_W_MCAUSE:    state_d = S_ASSERT;
      S_MRET_W:      state_d = S_MRET_ASSERT;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mst_trap               = csr.csr_mstatus;
    mst_trap[MSTATUS_MPIE] = csr.csr_mstatus[MSTATUS_MIE];
    mst_trap[MSTATUS_MIE]  = 1'b0;
    mst_mret               = csr.csr_mstatus;
    mst_mret[MSTATUS_MIE]  = csr.csr_mstatus[MSTATUS_MPIE];
    mst_mret[MSTATUS_MPIE] = 1'b1;
  end

`ifdef INT_VECTORED_EN
  always_comb begin
    trap_target = {csr.csr_mtvec[XLEN-1:2], 2'b00};
    if (csr.csr_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
      trap_target = {csr.csr_mtvec[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr.csr_mtvec[1:0];
  assign trap_target       = {csr.csr_mtvec[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    csr.csr_we    = 1'b0;
    csr.csr_waddr = '0;
    csr.csr_wdata = '0;
    int_assert_o  = 1'b0;
    int_addr_o    = RESET_VEC;
    hold_flag_o   = (state_q != S_IDLE) || evt_valid;
    case (state_q)
      S_W_MEPC: begin
        csr.csr_we    = 1'b1;
        csr.csr_waddr = XLEN'(CSR_MEPC);
        csr.csr_wdata = ret_addr_q;
      end
      S_W_MSTATUS: begin
        csr.csr_we    = 1'b1;
        csr.csr_waddr = XLEN'(CSR_MSTATUS);
        csr.csr_wdata = mst_trap;
      end
      S_W_MCAUSE: begin
        csr.csr_we    = 1'b1;
        csr.csr_waddr = XLEN'(CSR_MCAUSE);
        csr.csr_wdata = cause_q;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = trap_target;
      end
      S_MRET_W: begin
        csr.csr_we    = 1'b1;
        csr.csr_waddr = XLEN'(CSR_MSTATUS);
        csr.csr_wdata = mst_mret;
      end
      S_MRET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr.csr_mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with hand-computed CSR write and redirect expectations.
module tb_csr_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] inst_addr = '0, jump_addr = '0;
  logic            ecall = 0, ebreak = 0, mret = 0, jump_flag = 0, ext_irq = 0, tmr_irq = 0;
  logic            hold_flag, int_assert;
  logic [XLEN-1:0] int_addr;
  int              n_tests = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.XLEN(XLEN)) csr_bus ();

  csr_trap_ctrl #(.XLEN(XLEN), .RESET_VEC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_i  (inst_addr),
    .ecall_i      (ecall),
    .ebreak_i     (ebreak),
    .mret_i       (mret),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .ext_irq_i    (ext_irq),
    .tmr_irq_i    (tmr_irq),
    .csr          (csr_bus),
    .hold_flag_o  (hold_flag),
    .int_assert_o (int_assert),
    .int_addr_o   (int_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_we"},   {31'b0, csr_bus.csr_we}, 32'd1);
    chk({tag, "_addr"}, csr_bus.csr_waddr, {20'b0, a});
    chk({tag, "_data"}, csr_bus.csr_wdata, d);
    chk({tag, "_hold"}, {31'b0, hold_flag}, 32'd1);
  endtask

  task automatic exp_assert(input string tag, input logic [31:0] a);
    chk({tag, "_int"},  {31'b0, int_assert}, 32'd1);
    chk({tag, "_addr"}, int_addr, a);
    chk({tag, "_we"},   {31'b0, csr_bus.csr_we}, 32'd0);
    chk({tag, "_hold"}, {31'b0, hold_flag}, 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_hold"},  {31'b0, hold_flag}, 32'd0);
    chk({tag, "_we"},    {31'b0, csr_bus.csr_we}, 32'd0);
    chk({tag, "_waddr"}, csr_bus.csr_waddr, 32'd0);
    chk({tag, "_wdata"}, csr_bus.csr_wdata, 32'd0);
    chk({tag, "_int"},   {31'b0, int_assert}, 32'd0);
    chk({tag, "_iaddr"}, int_addr, 32'd0);
  endtask

  task automatic exp_detect(input string tag);
    #1;
    chk({tag, "_det_hold"}, {31'b0, hold_flag}, 32'd1);
    chk({tag, "_det_we"},   {31'b0, csr_bus.csr_we}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_bus.csr_mtvec     = 32'h200;
    csr_bus.csr_mepc      = 32'h0;
    csr_bus.csr_mstatus   = 32'h8;
    csr_bus.global_int_en = 1'b1;
    #1;
    exp_idle("rst");
    tick();
    tick();
    exp_idle("rst_hold");
    rst_n = 1'b1;
    tick();

    // ecall: three writes then redirect on the fourth cycle after detect
    inst_addr = 32'h100; ecall = 1;
    exp_detect("ecall");
    tick(); ecall = 0;
    exp_wr("ecall_mepc", 12'h341, 32'h100);
    tick(); exp_wr("ecall_mst", 12'h300, 32'h80);
    tick(); exp_wr("ecall_mcause", 12'h342, 32'h0000_000B);
    tick(); exp_assert("ecall_as", 32'h200);
    tick(); exp_idle("ecall_end");

    // external irq with a redirect pending in EX
    inst_addr = 32'h500; jump_flag = 1; jump_addr = 32'h340; ext_irq = 1;
    exp_detect("ext");
    tick(); jump_flag = 0; csr_bus.global_int_en = 1'b0;
    exp_wr("ext_mepc", 12'h341, 32'h340);
    tick(); exp_wr("ext_mst", 12'h300, 32'h80);
    tick(); exp_wr("ext_mcause", 12'h342, 32'h8000_000B);
    tick(); exp_assert("ext_as", 32'h200);
    tick(); exp_idle("ext_masked0");
    tick(); exp_idle("ext_masked1");
    ext_irq = 0;

    // timer irq at top of address space: return address wraps to 0; vectored mtvec
    csr_bus.global_int_en = 1'b1; csr_bus.csr_mtvec = 32'h201;
    inst_addr = 32'hFFFF_FFFC; tmr_irq = 1;
    exp_detect("tmr");
    tick(); tmr_irq = 0;
    exp_wr("tmr_mepc", 12'h341, 32'h0);
    tick(); exp_wr("tmr_mst", 12'h300, 32'h80);
    tick(); exp_wr("tmr_mcause", 12'h342, 32'h8000_0007);
    tick();
`ifdef INT_VECTORED_EN
    exp_assert("tmr_as", 32'h21C);
`else
    exp_assert("tmr_as", 32'h200);
`endif
    tick(); exp_idle("tmr_end");

    // ebreak with vectored mtvec still uses base; mret mid-sequence is ignored
    inst_addr = 32'h300; ebreak = 1;
    exp_detect("ebrk");
    tick(); ebreak = 0; mret = 1;
    exp_wr("ebrk_mepc", 12'h341, 32'h300);
    tick(); mret = 0;
    exp_wr("ebrk_mst", 12'h300, 32'h80);
    tick(); exp_wr("ebrk_mcause", 12'h342, 32'h3);
    tick(); exp_assert("ebrk_as", 32'h200);
    tick(); exp_idle("ebrk_end");

    // mret: restore MIE from MPIE, redirect to mepc two cycles after detect
    csr_bus.csr_mtvec = 32'h200; csr_bus.csr_mstatus = 32'h80; csr_bus.csr_mepc = 32'h104;
    mret = 1;
    exp_detect("mret");
    tick(); mret = 0;
    exp_wr("mret_mst", 12'h300, 32'h88);
    tick(); exp_assert("mret_as", 32'h104);
    tick(); exp_idle("mret_end");

    // ecall beats timer; timer stays masked once MIE drops
    csr_bus.csr_mstatus = 32'h8; inst_addr = 32'h600; ecall = 1; tmr_irq = 1;
    exp_detect("both");
    tick(); ecall = 0; csr_bus.global_int_en = 1'b0;
    exp_wr("both_mepc", 12'h341, 32'h600);
    tick(); exp_wr("both_mst", 12'h300, 32'h80);
    tick(); exp_wr("both_mcause", 12'h342, 32'h0000_000B);
    tick(); exp_assert("both_as", 32'h200);
    tick(); exp_idle("both_end");
    tmr_irq = 0;

    // reset during W_MSTATUS, then a clean full sequence
    csr_bus.global_int_en = 1'b1; inst_addr = 32'h700; ecall = 1;
    tick(); ecall = 0;
    tick(); exp_wr("rmid_mst", 12'h300, 32'h80);
    #1 rst_n = 1'b0;
    #1 exp_idle("rmid");
    #2 rst_n = 1'b1;
    tick();
    exp_idle("rmid_after");
    inst_addr = 32'h800; ecall = 1;
    exp_detect("rec");
    tick(); ecall = 0;
    exp_wr("rec_mepc", 12'h341, 32'h800);
    tick(); exp_wr("rec_mst", 12'h300, 32'h80);
    tick(); exp_wr("rec_mcause", 12'h342, 32'h0000_000B);
    tick(); exp_assert("rec_as", 32'h200);
    tick(); exp_idle("rec_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
